spike_dispatch_scheduler: RTL and testbench
===========================================

Name: spike_dispatch_scheduler

Overview:
Front-end scheduler for the AC synapse array. It accepts pre-synaptic spike IDs from two requesters, the external AER input and recurrent spikes from the neuron layer, and arbitrates them round-robin into a shared FIFO. It issues one spike at a time to the synapse array, respecting that array's busy/idle protocol. It also implements the end-of-timestep barrier: it blocks new input, drains the FIFO and the array, then signals completion.

Parameters:
PRE_ID_WIDTH, 6, width of pre-synaptic neuron ID
FIFO_DEPTH, 16, spike FIFO entries (power of 2)
FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
enable  in  1  global enable; low freezes scheduler
ext_spike_valid  in  1  external spike request
ext_spike_id  in  PRE_ID_WIDTH  external spike pre-ID
ext_spike_ready  out  1  external spike accepted this cycle when valid&ready
rec_spike_valid  in  1  recurrent spike request
rec_spike_id  in  PRE_ID_WIDTH  recurrent spike pre-ID
rec_spike_ready  out  1  recurrent spike accepted when valid&ready
syn_spike_valid  out  1  spike to synapse array (drives its spike_in_valid)
syn_spike_pre_id  out  PRE_ID_WIDTH  spike pre-ID to synapse array
syn_busy  in  1  synapse array busy
ts_tick  in  1  end-of-timestep request pulse
ts_done  out  1  one-cycle pulse: timestep fully drained
fifo_level  out  FIFO_AW+1  current FIFO occupancy
dispatch_count  out  32  spikes issued since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM in D_IDLE, rr_ptr=ext, ts_pending=0, FIFO empty.
- Arbitration (combinational ready):
  - space = !full & !ts_pending & enable.
  - If only one source is valid, it is granted.
  - If both are valid, the source pointed to by rr_ptr is granted; rr_ptr moves to the other source after any accepted grant.
  - ready=1 only for the granted source when space=1.
  - At most one push per cycle.
  - Requesters hold valid/id stable until ready (AXI-stream rule).
- FIFO: full and empty are evaluated on the current occupancy. A push at full is blocked even if a pop happens in the same cycle. Simultaneous push and pop at non-full leaves the level unchanged.
- Dispatch FSM (advances only when enable=1):
  - D_IDLE: if FIFO non-empty and !ts-gated, pop the head, register syn_spike_pre_id and syn_spike_valid=1, go to D_ISSUE.
  - D_ISSUE: hold valid and ID stable until syn_busy=1, then deassert valid, increment dispatch_count, go to D_DRAIN.
  - D_DRAIN: wait for syn_busy=0, then go to D_IDLE.
  - Result: exactly one capture per spike (the array captures only in its IDLE, and busy rises the cycle after capture).
- Latency: a spike accepted in cycle c shows syn_spike_valid=1 in cycle c+2 when the FSM is idle and the FIFO was empty.
- Timestep barrier:
  - ts_tick sets ts_pending at the clock edge; a push in the same cycle as the tick is still accepted.
  - While ts_pending=1, both readies are 0 and the FIFO continues draining.
  - ts_done pulses for one cycle when ts_pending & FIFO empty & FSM=D_IDLE & !syn_busy; ts_pending clears in that same edge.
  - A tick while ts_pending=1 is ignored.
  - A tick with everything already idle gives ts_done 1 cycle later.
- enable=0: no push (readies 0), no pop, FSM, counters and outputs hold, ts_done is not generated. ts_tick is still latched into ts_pending.
- dispatch_count wraps modulo 2^32.
- Reset mid-operation clears the FIFO and any in-flight valid. The external synapse array is reset by the same rst_n.

Decomposition:
- Shared header snn_defines.vh: PRE_ID_WIDTH default, dispatch FSM state encodings (D_IDLE, D_ISSUE, D_DRAIN), source encodings (SRC_EXT, SRC_REC).
- One sub-module: spike_fifo_sync, a synchronous FIFO with width/depth parameters, push/pop/full/empty/level, registered read at pop.
- Arbiter and FSM live in the top module.

Test Plan:
- Single ext spike id=5, syn_busy model goes high 1 cycle after capture and low 258 cycles later -> syn_spike_valid in c+2, high exactly 2 cycles, pre_id=5, dispatch_count=1.
- ext and rec both valid continuously with IDs 1..8 and 101..108 (mod 64) -> accepted order alternates ext, rec, ext, ...; dispatched order identical; no loss.
- Fill FIFO with 16 spikes while syn_busy is held high -> fifo_level=16, both readies 0; after busy drops, a pop occurs and ready returns the next cycle.
- 3 queued spikes then ts_tick -> readies drop, all 3 dispatched, ts_done pulses once after the final busy falls; a second tick during drain produces no extra pulse.
- enable=0 during D_ISSUE for 10 cycles -> valid and ID held, no FIFO change; resumes correctly once enable=1.
- Assert rst_n low with 5 queued spikes and syn_spike_valid=1 -> all outputs 0 immediately (asynchronous), fifo_level=0.

Source files
------------

// File: rtl/spike_dispatch_scheduler_pkg.sv
// Shared types for the spike dispatch scheduler: dispatch FSM states,
// requester encodings and the default pre-synaptic ID width.
package spike_dispatch_scheduler_pkg;

  localparam int PRE_ID_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_DRAIN = 2'd2
  } disp_state_e;

  typedef enum logic {
    SRC_EXT = 1'b0,
    SRC_REC = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_EXT) ? SRC_REC : SRC_EXT;
  endfunction

endpackage

// File: rtl/spike_dispatch_scheduler_if.sv
// Spike request channels (external AER, recurrent) and the synapse-array
// issue channel. master = requesters/array side, slave = scheduler side.
interface spike_dispatch_scheduler_if
  import spike_dispatch_scheduler_pkg::*;
#(parameter int PRE_ID_WIDTH = PRE_ID_WIDTH_DEF) ();

  logic                    ext_spike_valid;
  logic [PRE_ID_WIDTH-1:0] ext_spike_id;
  logic                    ext_spike_ready;
  logic                    rec_spike_valid;
  logic [PRE_ID_WIDTH-1:0] rec_spike_id;
  logic                    rec_spike_ready;
  logic                    syn_spike_valid;
  logic [PRE_ID_WIDTH-1:0] syn_spike_pre_id;
  logic                    syn_busy;

  modport master (
    output ext_spike_valid, ext_spike_id, rec_spike_valid, rec_spike_id, syn_busy,
    input  ext_spike_ready, rec_spike_ready, syn_spike_valid, syn_spike_pre_id
  );

  modport slave (
    input  ext_spike_valid, ext_spike_id, rec_spike_valid, rec_spike_id, syn_busy,
    output ext_spike_ready, rec_spike_ready, syn_spike_valid, syn_spike_pre_id
  );

endinterface

// File: rtl/spike_fifo_sync.sv
// Synchronous FIFO; pop_data is registered at pop and held until the next pop.
// full/empty reflect current occupancy, so a push at full is dropped.
module spike_fifo_sync #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        pop_data <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_dispatch_scheduler.sv
// Round-robin merge of external and recurrent spikes into a FIFO, one-at-a-time
// issue to the synapse array, and the end-of-timestep drain barrier.
module spike_dispatch_scheduler
  import spike_dispatch_scheduler_pkg::*;
#(
  parameter int PRE_ID_WIDTH = PRE_ID_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  spike_dispatch_scheduler_if.slave  bus,
  input  logic                       ts_tick,
  output logic                       ts_done,
  output logic [FIFO_AW:0]           fifo_level,
  output logic [31:0]                dispatch_count
);

  disp_state_e             state;
  src_e                    rr_ptr, grant;
  logic                    ts_pending;
  logic                    space, push, pop, full, empty;
  logic [PRE_ID_WIDTH-1:0] push_id, head_id;

  always_comb begin
    space = !full && !ts_pending && enable;
    grant = rr_ptr;
    if (bus.ext_spike_valid && !bus.rec_spike_valid)      grant = SRC_EXT;
    else if (!bus.ext_spike_valid && bus.rec_spike_valid) grant = SRC_REC;
    bus.ext_spike_ready = space && bus.ext_spike_valid && (grant == SRC_EXT);
    bus.rec_spike_ready = space && bus.rec_spike_valid && (grant == SRC_REC);
    push    = bus.ext_spike_ready || bus.rec_spike_ready;
    push_id = (grant == SRC_EXT) ? bus.ext_spike_id : bus.rec_spike_id;
    pop     = enable && (state == D_IDLE) && !empty;
    // Barrier completes only once nothing is queued, issued or in the array.
    ts_done = enable && ts_pending && empty && (state == D_IDLE) && !bus.syn_busy;
  end

  spike_fifo_sync #(
    .WIDTH (PRE_ID_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_id),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // The FIFO's registered read doubles as the issued ID, stable until next pop.
  assign bus.syn_spike_pre_id = head_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= D_IDLE;
      bus.syn_spike_valid <= 1'b0;
      dispatch_count      <= '0;
      rr_ptr              <= SRC_EXT;
      ts_pending          <= 1'b0;
    end else begin
      if (push) rr_ptr <= other_src(grant);
      if (ts_done)      ts_pending <= 1'b0;
      else if (ts_tick) ts_pending <= 1'b1;
      if (enable) begin
        case (state)
          D_IDLE: if (pop) begin
            bus.syn_spike_valid <= 1'b1;
            state               <= D_ISSUE;
          end
          // Busy rising is the array's acknowledgement of the capture.
          D_ISSUE: if (bus.syn_busy) begin
            bus.syn_spike_valid <= 1'b0;
            dispatch_count      <= dispatch_count + 32'd1;
            state               <= D_DRAIN;
          end
          D_DRAIN: if (!bus.syn_busy) state <= D_IDLE;
          default: state <= D_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// Bench for spike_dispatch_scheduler: synapse-array model with capture queue,
// expected-ID scoreboard, arbitration vector table and barrier/reset sequences.
module tb_spike_dispatch_scheduler;
  localparam int W = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        ts_tick = 1'b0;
  logic        ts_done;
  logic [4:0]  fifo_level;
  logic [31:0] dispatch_count;

  spike_dispatch_scheduler_if #(.PRE_ID_WIDTH(W)) bus ();

  spike_dispatch_scheduler #(.PRE_ID_WIDTH(W), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus), .ts_tick(ts_tick),
    .ts_done(ts_done), .fifo_level(fifo_level), .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  // Synapse array: captures when idle and valid, busy from the next cycle for busy_len cycles.
  int          busy_len = 2;
  int          bcnt = 0;
  logic [W-1:0] cap_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.syn_busy <= 1'b0;
      bcnt <= 0;
      cap_q.delete();
    end else if (bus.syn_busy) begin
      if (bcnt <= 1) bus.syn_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (bus.syn_spike_valid) begin
      bus.syn_busy <= 1'b1;
      bcnt <= busy_len;
      cap_q.push_back(bus.syn_spike_pre_id);
    end
  end

  int           n_cmp = 0, n_fail = 0;
  int           cap_rd = 0, exp_total = 0;
  logic [W-1:0] exp_q[$];

  typedef struct packed { logic en, ev, rv, er, rr; } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_ext(input logic [W-1:0] id);
    int n = 0;
    bus.ext_spike_valid = 1'b1;
    bus.ext_spike_id = id;
    @(negedge clk);
    while (!bus.ext_spike_ready && n < 200) begin @(negedge clk); n++; end
    check("send_accept", 32'(bus.ext_spike_ready), 32'd1);
    @(posedge clk); #1;
    bus.ext_spike_valid = 1'b0;
    exp_q.push_back(id);
  endtask

  task automatic drive_src(input bit rec, input int first, input int n);
    int w;
    logic [W-1:0] id;
    for (int k = 0; k < n; k++) begin
      id = W'(first + k);
      if (rec) begin bus.rec_spike_valid = 1'b1; bus.rec_spike_id = id; end
      else     begin bus.ext_spike_valid = 1'b1; bus.ext_spike_id = id; end
      w = 0;
      @(negedge clk);
      while (!(rec ? bus.rec_spike_ready : bus.ext_spike_ready) && w < 200) begin
        @(negedge clk); w++;
      end
      @(posedge clk); #1;
    end
    if (rec) bus.rec_spike_valid = 1'b0;
    else     bus.ext_spike_valid = 1'b0;
  endtask

  task automatic wait_cond_busy(input string name);
    int n = 0;
    while (!bus.syn_busy && n < 100) begin @(negedge clk); n++; end
    check(name, 32'(bus.syn_busy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic sb_check(input string name);
    int w = 0;
    logic [W-1:0] e;
    while (((cap_q.size() - cap_rd) < exp_q.size() || bus.syn_busy || bus.syn_spike_valid ||
            fifo_level != 0) && w < 4000) begin
      @(negedge clk); w++;
    end
    check({name, "_settle"}, 32'(w < 4000), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_total++;
      if (cap_rd < cap_q.size()) begin
        check({name, "_id"}, 32'(cap_q[cap_rd]), 32'(e));
        cap_rd++;
      end else check({name, "_missing"}, 32'(cap_q.size()), 32'(cap_rd + 1));
    end
    check({name, "_extra"}, 32'(cap_q.size() - cap_rd), 32'd0);
    check({name, "_count"}, dispatch_count, 32'(exp_total));
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, base, n;
    bus.ext_spike_valid = 1'b0; bus.ext_spike_id = '0;
    bus.rec_spike_valid = 1'b0; bus.rec_spike_id = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.syn_spike_valid), 32'd0);
    check("rst_id", 32'(bus.syn_spike_pre_id), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_count", dispatch_count, 32'd0);
    check("rst_ts_done", 32'(ts_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;

    // Both requesters streaming: strict ext/rec alternation from the reset pointer.
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(W'(1 + k));
      exp_q.push_back(W'(101 + k));
    end
    fork
      drive_src(1'b0, 1, 8);
      drive_src(1'b1, 101, 8);
    join
    sb_check("rr_stream");

    // Arbitration vectors: {enable, ext_valid, rec_valid, exp ext_ready, exp rec_ready}.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    begin
      logic [W-1:0] ext_next, rec_next;
      ext_next = 6'd20; rec_next = 6'd40;
      for (int i = 0; i < 11; i++) begin
        enable = tbl[i].en;
        bus.ext_spike_valid = tbl[i].ev; bus.ext_spike_id = ext_next;
        bus.rec_spike_valid = tbl[i].rv; bus.rec_spike_id = rec_next;
        @(negedge clk);
        check($sformatf("tbl%0d_ext_ready", i), 32'(bus.ext_spike_ready), 32'(tbl[i].er));
        check($sformatf("tbl%0d_rec_ready", i), 32'(bus.rec_spike_ready), 32'(tbl[i].rr));
        if (tbl[i].er) begin exp_q.push_back(ext_next); ext_next++; end
        if (tbl[i].rr) begin exp_q.push_back(rec_next); rec_next++; end
        @(posedge clk); #1;
      end
    end
    bus.ext_spike_valid = 1'b0; bus.rec_spike_valid = 1'b0; enable = 1'b1;
    sb_check("tbl");

    // Single spike latency and valid width against a long-busy array.
    busy_len = 258;
    bus.ext_spike_valid = 1'b1; bus.ext_spike_id = 6'd5;
    @(negedge clk);
    check("lat_ready", 32'(bus.ext_spike_ready), 32'd1);
    @(posedge clk); #1;
    bus.ext_spike_valid = 1'b0;
    exp_q.push_back(6'd5);
    @(negedge clk); check("lat_c1_valid", 32'(bus.syn_spike_valid), 32'd0);
    @(negedge clk); check("lat_c2_valid", 32'(bus.syn_spike_valid), 32'd1);
    check("lat_c2_id", 32'(bus.syn_spike_pre_id), 32'd5);
    @(negedge clk); check("lat_c3_valid", 32'(bus.syn_spike_valid), 32'd1);
    @(negedge clk); check("lat_c4_valid", 32'(bus.syn_spike_valid), 32'd0);
    @(posedge clk); #1;
    sb_check("lat");

    // Fill to full while the array is busy, then watch ready return after a pop.
    busy_len = 60;
    send_ext(6'd10);
    wait_cond_busy("full_busy");
    for (int k = 0; k < 16; k++) send_ext(W'(11 + k));
    bus.ext_spike_valid = 1'b1; bus.ext_spike_id = 6'd27;
    bus.rec_spike_valid = 1'b1; bus.rec_spike_id = 6'd50;
    @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ext_ready", 32'(bus.ext_spike_ready), 32'd0);
    check("full_rec_ready", 32'(bus.rec_spike_ready), 32'd0);
    @(posedge clk); #1;
    bus.rec_spike_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (fifo_level == 5'd16 && n < 100) begin @(negedge clk); n++; end
    busy_len = 3;
    check("full_after_pop_level", 32'(fifo_level), 32'd15);
    check("full_after_pop_ready", 32'(bus.ext_spike_ready), 32'd1);
    @(posedge clk); #1;
    bus.ext_spike_valid = 1'b0;
    exp_q.push_back(6'd27);
    sb_check("full");

    // Barrier: tick coincides with the third push, then drain with one pulse.
    send_ext(6'd1);
    send_ext(6'd2);
    bus.ext_spike_valid = 1'b1; bus.ext_spike_id = 6'd3; ts_tick = 1'b1;
    @(negedge clk);
    check("ts_push_with_tick", 32'(bus.ext_spike_ready), 32'd1);
    @(posedge clk); #1;
    ts_tick = 1'b0;
    exp_q.push_back(6'd3);
    bus.ext_spike_id = 6'd4;
    bus.rec_spike_valid = 1'b1; bus.rec_spike_id = 6'd5;
    @(negedge clk);
    check("ts_ext_blocked", 32'(bus.ext_spike_ready), 32'd0);
    check("ts_rec_blocked", 32'(bus.rec_spike_ready), 32'd0);
    @(posedge clk); #1;
    bus.ext_spike_valid = 1'b0; bus.rec_spike_valid = 1'b0;
    pulses = 0;
    base = exp_total + 3;
    for (int c = 0; c < 60; c++) begin
      if (c == 2) ts_tick = 1'b1;
      if (c == 3) ts_tick = 1'b0;
      @(negedge clk);
      if (ts_done) begin
        pulses++;
        check("ts_done_level", 32'(fifo_level), 32'd0);
        check("ts_done_count", dispatch_count, 32'(base));
        check("ts_done_busy", 32'(bus.syn_busy), 32'd0);
      end
    end
    check("ts_pulses", 32'(pulses), 32'd1);
    @(posedge clk); #1;
    sb_check("ts");

    // Tick with everything idle: done on the following cycle only.
    ts_tick = 1'b1;
    @(negedge clk); check("ts_idle_c0", 32'(ts_done), 32'd0);
    @(posedge clk); #1;
    ts_tick = 1'b0;
    @(negedge clk); check("ts_idle_c1", 32'(ts_done), 32'd1);
    @(negedge clk); check("ts_idle_c2", 32'(ts_done), 32'd0);
    @(posedge clk); #1;

    // Freeze with enable low while an issue is outstanding.
    busy_len = 20;
    send_ext(6'd12);
    send_ext(6'd13);
    n = 0;
    @(negedge clk);
    while (!bus.syn_spike_valid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    enable = 1'b0;
    bus.ext_spike_valid = 1'b1; bus.ext_spike_id = 6'd14;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("frz%0d_valid", c), 32'(bus.syn_spike_valid), 32'd1);
      check($sformatf("frz%0d_id", c), 32'(bus.syn_spike_pre_id), 32'd12);
      check($sformatf("frz%0d_level", c), 32'(fifo_level), 32'd1);
      check($sformatf("frz%0d_ready", c), 32'(bus.ext_spike_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.ext_spike_valid = 1'b0;
    enable = 1'b1;
    sb_check("frz");

    // Asynchronous reset with a spike on the wire and five queued behind it.
    busy_len = 40;
    send_ext(6'd30);
    wait_cond_busy("rst_mid_busy");
    for (int k = 0; k < 6; k++) send_ext(W'(31 + k));
    n = 0;
    @(negedge clk);
    while (!bus.syn_spike_valid && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_level_before", 32'(fifo_level), 32'd5);
    check("rst_mid_id_before", 32'(bus.syn_spike_pre_id), 32'd31);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.syn_spike_valid), 32'd0);
    check("rst_mid_id", 32'(bus.syn_spike_pre_id), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    check("rst_mid_count", dispatch_count, 32'd0);
    check("rst_mid_ts_done", 32'(ts_done), 32'd0);
    exp_q.delete();
    exp_total = 0;
    cap_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_ext(6'd9);
    sb_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
